// File: rtl/dct_defs.sv
// rtl/dct_defs.sv - shared constants, fftpts legality check and cosine table math
package dct_defs;

    localparam int DCT_W         = 18;
    localparam int DCT_MAX_LOG2N = 11;
    localparam int DCT_MIN_LOG2N = 4;
    localparam int DCT_NMAX      = 1 << DCT_MAX_LOG2N;
    localparam int DCT_S         = 1 << (DCT_W - 2);
    localparam int DCT_TWID_LAT  = 3;

    localparam logic [127:0] PI_Q48 = 128'h3243F6A8885A3;

    typedef struct packed {
        logic       legal;
        logic [4:0] log2n;
    } pts_chk_t;

    // Illegal lengths fall back to log2n = max_l so the frame still runs at Nmax.
    function automatic pts_chk_t check_fftpts(input logic [31:0] pts, input int min_l, input int max_l);
        pts_chk_t r;
        r.legal = 1'b0;
        r.log2n = 5'(max_l);
        for (int l = 0; l < 32; l++) begin
            if (pts == (32'd1 << l) && l >= min_l && l <= max_l) begin
                r.legal = 1'b1;
                r.log2n = 5'(l);
            end
        end
        return r;
    endfunction

    // round(2^(w-2) * cos(pi*idx/2^(log2nmax+1))) via Taylor series in Q48, elaboration-time only.
    function automatic logic signed [63:0] twid_cos(input int idx, input int log2nmax, input int w);
        logic [127:0]        x;
        logic [127:0]        x2;
        logic [127:0]        term;
        logic signed [127:0] acc;
        int                  rs;
        x    = (PI_Q48 * 128'(idx)) >> (log2nmax + 1);
        x2   = (x * x) >> 48;
        term = 128'd1 << 48;
        acc  = $signed(term);
        for (int n = 1; n <= 12; n++) begin
            term = ((term * x2) >> 48) / 128'((2 * n - 1) * (2 * n));
            if (n % 2 == 1) acc = acc - $signed(term);
            else            acc = acc + $signed(term);
        end
        rs  = 48 - (w - 2);
        acc = (acc + (128'sd1 <<< (rs - 1))) >>> rs;
        return acc[63:0];
    endfunction

endpackage

// File: rtl/dct_twiddle_rom.sv
// rtl/dct_twiddle_rom.sv - dual-read synchronous quarter-wave cosine ROM
module dct_twiddle_rom
    import dct_defs::*;
#(
    parameter int W     = DCT_W,
    parameter int LOG2N = DCT_MAX_LOG2N
) (
    input  logic             clk,
    input  logic [LOG2N-1:0] i_addr_a,
    input  logic [LOG2N-1:0] i_addr_b,
    output logic [W-1:0]     o_data_a,
    output logic [W-1:0]     o_data_b
);

    localparam int N = 1 << LOG2N;

    logic [W-1:0] w_rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam logic signed [63:0] V = twid_cos(g, LOG2N, W);
        assign w_rom[g] = V[W-1:0];
    end

    always_ff @(posedge clk) begin
        o_data_a <= w_rom[i_addr_a];
        o_data_b <= w_rom[i_addr_b];
    end

endmodule

// File: rtl/dct_twiddle_gen.sv
// rtl/dct_twiddle_gen.sv - DCT twiddle (cos/sin) generator, 3-stage pipeline
module dct_twiddle_gen
    import dct_defs::*;
#(
    parameter int wDataOut  = DCT_W,
    parameter int MAX_LOG2N = DCT_MAX_LOG2N,
    parameter int MIN_LOG2N = DCT_MIN_LOG2N
) (
    input  logic                       clk,
    input  logic                       rst_n_sync,
    input  logic                       sink_valid,
    input  logic                       sink_sop,
    input  logic [MAX_LOG2N:0]         fftpts_in,
    input  logic                       inverse,
    output logic                       source_valid,
    output logic                       source_sop,
    output logic                       source_eop,
    output logic signed [wDataOut-1:0] source_cos,
    output logic signed [wDataOut-1:0] source_sin,
    output logic                       cfg_err
);

    localparam int N_MAX = 1 << MAX_LOG2N;
    localparam logic signed [63:0]         K0_COS_FULL = twid_cos(N_MAX / 2, MAX_LOG2N, wDataOut);
    localparam logic signed [wDataOut-1:0] K0_COS      = K0_COS_FULL[wDataOut-1:0];

    logic [MAX_LOG2N-1:0] r_next_k;
    logic [4:0]           r_log2n;
    logic                 r_inv;

    logic                 r_s0_valid, r_s0_sop, r_s0_eop, r_s0_inv;
    logic [MAX_LOG2N-1:0] r_s0_addr;
    logic                 r_s1_valid, r_s1_sop, r_s1_eop, r_s1_inv, r_s1_zero;

    pts_chk_t             w_chk;
    logic [4:0]           w_log2n;
    logic [4:0]           w_shift;
    logic                 w_inv;
    logic [MAX_LOG2N-1:0] w_k, w_last, w_addr, w_sin_addr;
    logic [wDataOut-1:0]  w_rom_cos, w_rom_sin;

    assign w_chk = check_fftpts(32'(fftpts_in), MIN_LOG2N, MAX_LOG2N);

    always_comb begin
        w_log2n = r_log2n;
        w_inv   = r_inv;
        w_k     = r_next_k;
        if (sink_sop) begin
            w_log2n = w_chk.log2n;
            w_inv   = inverse;
            w_k     = '0;
        end
    end

    assign w_last     = MAX_LOG2N'((32'd1 << w_log2n) - 32'd1);
    assign w_shift    = 5'(MAX_LOG2N) - w_log2n;
    assign w_addr     = w_k << w_shift;
    // Nmax - addr taken modulo Nmax; the addr==0 case is overridden at stage 2.
    assign w_sin_addr = '0 - r_s0_addr;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_next_k   <= '0;
            r_log2n    <= 5'(MAX_LOG2N);
            r_inv      <= 1'b0;
            cfg_err    <= 1'b0;
            r_s0_valid <= 1'b0;
            r_s0_sop   <= 1'b0;
            r_s0_eop   <= 1'b0;
            r_s0_inv   <= 1'b0;
            r_s0_addr  <= '0;
        end else begin
            r_s0_valid <= sink_valid;
            if (sink_valid) begin
                r_next_k  <= (w_k == w_last) ? '0 : w_k + MAX_LOG2N'(1);
                r_log2n   <= w_log2n;
                r_inv     <= w_inv;
                r_s0_sop  <= (w_k == '0);
                r_s0_eop  <= (w_k == w_last);
                r_s0_inv  <= w_inv;
                r_s0_addr <= w_addr;
                if (sink_sop && !w_chk.legal) cfg_err <= 1'b1;
            end
        end
    end

    dct_twiddle_rom #(
        .W     (wDataOut),
        .LOG2N (MAX_LOG2N)
    ) u_rom (
        .clk      (clk),
        .i_addr_a (r_s0_addr),
        .i_addr_b (w_sin_addr),
        .o_data_a (w_rom_cos),
        .o_data_b (w_rom_sin)
    );

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            r_s1_valid   <= 1'b0;
            r_s1_sop     <= 1'b0;
            r_s1_eop     <= 1'b0;
            r_s1_inv     <= 1'b0;
            r_s1_zero    <= 1'b0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_cos   <= '0;
            source_sin   <= '0;
        end else begin
            r_s1_valid   <= r_s0_valid;
            r_s1_sop     <= r_s0_sop;
            r_s1_eop     <= r_s0_eop;
            r_s1_inv     <= r_s0_inv;
            r_s1_zero    <= (r_s0_addr == '0);
            source_valid <= r_s1_valid;
            source_sop   <= r_s1_valid & r_s1_sop;
            source_eop   <= r_s1_valid & r_s1_eop;
            if (r_s1_valid) begin
                source_cos <= r_s1_zero ? K0_COS : $signed(w_rom_cos);
                if (r_s1_zero)     source_sin <= '0;
                else if (r_s1_inv) source_sin <= -$signed(w_rom_sin);
                else               source_sin <= $signed(w_rom_sin);
            end
        end
    end

endmodule

// File: tb/tb_dct_twiddle_gen.sv
// tb/tb_dct_twiddle_gen.sv - self-checking bench for dct_twiddle_gen
module tb_dct_twiddle_gen;

    localparam int  W    = 18;
    localparam int  MAXL = 11;
    localparam int  MINL = 4;
    localparam int  PW   = MAXL + 1;
    localparam int  NMAX = 2048;
    localparam real S_R  = 65536.0;
    localparam real PI   = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst_n_sync = 1'b1;
    logic          sink_valid = 1'b0;
    logic          sink_sop = 1'b0;
    logic          inverse = 1'b0;
    logic [MAXL:0] fftpts_in = '0;
    logic          source_valid, source_sop, source_eop, cfg_err;
    logic signed [W-1:0] source_cos, source_sin;

    typedef struct {
        int cos_v;
        int sin_v;
        bit sop;
        bit eop;
        int t;
    } item_t;

    item_t exp_q[$];
    item_t got_q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int m_k = 0;
    int m_n = NMAX;
    bit m_inv = 1'b0;

    dct_twiddle_gen #(
        .wDataOut  (W),
        .MAX_LOG2N (MAXL),
        .MIN_LOG2N (MINL)
    ) dut (
        .clk          (clk),
        .rst_n_sync   (rst_n_sync),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .fftpts_in    (fftpts_in),
        .inverse      (inverse),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_cos   (source_cos),
        .source_sin   (source_sin),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n_sync && source_valid) begin
            item_t g;
            g.cos_v = int'(source_cos);
            g.sin_v = int'(source_sin);
            g.sop   = source_sop;
            g.eop   = source_eop;
            g.t     = cyc;
            got_q.push_back(g);
        end
    end

    function automatic bit legal(input int pts);
        return ($countones(pts) == 1) && (pts >= (1 << MINL)) && (pts <= NMAX);
    endfunction

    function automatic int rnd(input real x);
        return (x < 0.0) ? -$rtoi(0.5 - x) : $rtoi(x + 0.5);
    endfunction

    task automatic req(input bit sop, input int pts, input bit inv);
        item_t e;
        @(posedge clk); #1;
        sink_valid = 1'b1;
        sink_sop   = sop;
        fftpts_in  = pts[MAXL:0];
        inverse    = inv;
        if (sop) begin
            m_n   = legal(pts) ? pts : NMAX;
            m_inv = inv;
            m_k   = 0;
        end
        e.t   = cyc;
        e.sop = (m_k == 0);
        e.eop = (m_k == m_n - 1);
        if (m_k == 0) begin
            e.cos_v = rnd(S_R / $sqrt(2.0));
            e.sin_v = 0;
        end else begin
            e.cos_v = rnd(S_R * $cos(PI * m_k / (2.0 * m_n)));
            e.sin_v = rnd(S_R * $sin(PI * m_k / (2.0 * m_n)));
            if (m_inv) e.sin_v = -e.sin_v;
        end
        exp_q.push_back(e);
        m_k = (m_k + 1) % m_n;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sink_valid = 1'b0;
            sink_sop   = 1'($urandom);
            fftpts_in  = PW'($urandom);
            inverse    = 1'($urandom);
        end
    endtask

    task automatic test_reset;
        #3 rst_n_sync = 1'b0;
        #1;
        n_chk++;
        if ({source_valid, source_sop, source_eop, cfg_err} !== 4'b0 || source_cos !== '0 || source_sin !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b sop=%b eop=%b err=%b cos=%0d sin=%0d, required all 0",
                     source_valid, source_sop, source_eop, cfg_err, source_cos, source_sin);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n_sync = 1'b1;
    endtask

    task automatic test_fwd_2048;
        exp_q.delete(); got_q.delete();
        req(1'b1, 2048, 1'b0);
        for (int i = 1; i < 2048; i++) req(1'b0, $urandom, 1'($urandom));
        idle(6);
        n_chk++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL fwd_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i].cos_v !== exp_q[i].cos_v || got_q[i].sin_v !== exp_q[i].sin_v || got_q[i].sop !== exp_q[i].sop
                || got_q[i].eop !== exp_q[i].eop || got_q[i].t - exp_q[i].t !== 3) begin
                n_fail++;
                $display("FAIL fwd_item %0d: got cos=%0d sin=%0d sop=%0d eop=%0d lat=%0d, required cos=%0d sin=%0d sop=%0d eop=%0d lat=3",
                         i, got_q[i].cos_v, got_q[i].sin_v, got_q[i].sop, got_q[i].eop, got_q[i].t - exp_q[i].t,
                         exp_q[i].cos_v, exp_q[i].sin_v, exp_q[i].sop, exp_q[i].eop);
            end
        end
        if (got_q.size() == 2048) begin
            n_chk++;
            if (got_q[0].cos_v !== 46341 || got_q[0].sin_v !== 0 || got_q[1].cos_v !== 65536 || got_q[1].sin_v !== 50
                || got_q[1024].cos_v !== 46341 || got_q[1024].sin_v !== 46341 || got_q[2047].eop !== 1'b1) begin
                n_fail++;
                $display("FAIL fwd_spot: got k0=(%0d,%0d) k1=(%0d,%0d) k1024=(%0d,%0d) eop2047=%0d, required (46341,0) (65536,50) (46341,46341) 1",
                         got_q[0].cos_v, got_q[0].sin_v, got_q[1].cos_v, got_q[1].sin_v,
                         got_q[1024].cos_v, got_q[1024].sin_v, got_q[2047].eop);
            end
        end
    endtask

    task automatic test_inverse_16;
        int sops;
        exp_q.delete(); got_q.delete();
        req(1'b1, 16, 1'b1);
        for (int i = 1; i < 32; i++) req(1'b0, $urandom, 1'($urandom));
        idle(6);
        n_chk++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL inv_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
        end
        sops = 0;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            sops += got_q[i].sop;
            if (got_q[i].cos_v !== exp_q[i].cos_v || got_q[i].sin_v !== exp_q[i].sin_v || got_q[i].sop !== exp_q[i].sop
                || got_q[i].eop !== exp_q[i].eop || got_q[i].t - exp_q[i].t !== 3) begin
                n_fail++;
                $display("FAIL inv_item %0d: got cos=%0d sin=%0d sop=%0d eop=%0d, required cos=%0d sin=%0d sop=%0d eop=%0d",
                         i, got_q[i].cos_v, got_q[i].sin_v, got_q[i].sop, got_q[i].eop,
                         exp_q[i].cos_v, exp_q[i].sin_v, exp_q[i].sop, exp_q[i].eop);
            end
        end
        n_chk++;
        if (got_q.size() < 16 || got_q[8].cos_v !== 46341 || got_q[8].sin_v !== -46341
            || got_q[15].cos_v !== 6424 || got_q[15].sin_v !== -65220 || sops !== 2) begin
            n_fail++;
            $display("FAIL inv_spot: got k8=(%0d,%0d) k15=(%0d,%0d) sops=%0d, required (46341,-46341) (6424,-65220) 2",
                     got_q[8].cos_v, got_q[8].sin_v, got_q[15].cos_v, got_q[15].sin_v, sops);
        end
        n_chk++;
        if (source_valid !== 1'b0 || int'(source_cos) !== exp_q[31].cos_v || int'(source_sin) !== exp_q[31].sin_v) begin
            n_fail++;
            $display("FAIL inv_hold: got v=%b cos=%0d sin=%0d, required v=0 cos=%0d sin=%0d",
                     source_valid, source_cos, source_sin, exp_q[31].cos_v, exp_q[31].sin_v);
        end
    endtask

    task automatic test_gaps_64;
        exp_q.delete(); got_q.delete();
        req(1'b1, 64, 1'b0);
        for (int i = 1; i < 64; i++) begin
            idle(1);
            req(1'b0, $urandom, 1'($urandom));
        end
        idle(6);
        n_chk++;
        if (got_q.size() != 64) begin
            n_fail++;
            $display("FAIL gap_count: got %0d outputs, required 64", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i].cos_v !== exp_q[i].cos_v || got_q[i].sin_v !== exp_q[i].sin_v || got_q[i].sop !== exp_q[i].sop
                || got_q[i].eop !== exp_q[i].eop || got_q[i].t - exp_q[i].t !== 3) begin
                n_fail++;
                $display("FAIL gap_item %0d: got cos=%0d sin=%0d eop=%0d lat=%0d, required cos=%0d sin=%0d eop=%0d lat=3",
                         i, got_q[i].cos_v, got_q[i].sin_v, got_q[i].eop, got_q[i].t - exp_q[i].t,
                         exp_q[i].cos_v, exp_q[i].sin_v, exp_q[i].eop);
            end
        end
    endtask

    task automatic test_resync;
        int eops;
        exp_q.delete(); got_q.delete();
        req(1'b1, 256, 1'b0);
        for (int i = 1; i < 100; i++) req(1'b0, $urandom, 1'($urandom));
        req(1'b1, 32, 1'b0);
        for (int i = 1; i < 40; i++) req(1'b0, $urandom, 1'($urandom));
        idle(6);
        n_chk++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL resync_count: got %0d outputs, required %0d", got_q.size(), exp_q.size());
        end
        eops = 0;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (i < 100) eops += got_q[i].eop;
            if (got_q[i].cos_v !== exp_q[i].cos_v || got_q[i].sin_v !== exp_q[i].sin_v || got_q[i].sop !== exp_q[i].sop
                || got_q[i].eop !== exp_q[i].eop || got_q[i].t - exp_q[i].t !== 3) begin
                n_fail++;
                $display("FAIL resync_item %0d: got cos=%0d sin=%0d sop=%0d eop=%0d, required cos=%0d sin=%0d sop=%0d eop=%0d",
                         i, got_q[i].cos_v, got_q[i].sin_v, got_q[i].sop, got_q[i].eop,
                         exp_q[i].cos_v, exp_q[i].sin_v, exp_q[i].sop, exp_q[i].eop);
            end
        end
        n_chk++;
        if (got_q.size() < 132 || got_q[100].sop !== 1'b1 || got_q[100].cos_v !== 46341 || eops !== 0 || got_q[131].eop !== 1'b1) begin
            n_fail++;
            $display("FAIL resync_spot: got sop100=%0d cos100=%0d eops_before=%0d eop131=%0d, required 1 46341 0 1",
                     got_q[100].sop, got_q[100].cos_v, eops, got_q[131].eop);
        end
    endtask

    task automatic test_random;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(3) == 0) idle(1);
            else req($urandom_range(40) == 0, 1 << $urandom_range(MAXL, MINL), 1'($urandom));
        end
        idle(6);
        n_chk++;
        if (got_q.size() != exp_q.size() || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d outputs err=%b, required %0d err=0", got_q.size(), cfg_err, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i].cos_v !== exp_q[i].cos_v || got_q[i].sin_v !== exp_q[i].sin_v || got_q[i].sop !== exp_q[i].sop
                || got_q[i].eop !== exp_q[i].eop || got_q[i].t - exp_q[i].t !== 3) begin
                n_fail++;
                $display("FAIL rand_item %0d: got cos=%0d sin=%0d sop=%0d eop=%0d lat=%0d, required cos=%0d sin=%0d sop=%0d eop=%0d lat=3",
                         i, got_q[i].cos_v, got_q[i].sin_v, got_q[i].sop, got_q[i].eop, got_q[i].t - exp_q[i].t,
                         exp_q[i].cos_v, exp_q[i].sin_v, exp_q[i].sop, exp_q[i].eop);
            end
        end
    endtask

    task automatic test_cfg_err;
        exp_q.delete(); got_q.delete();
        req(1'b1, 1536, 1'b0);
        n_chk++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_before: got %b, required 0", cfg_err);
        end
        req(1'b0, $urandom, 1'($urandom));
        n_chk++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_set: got %b, required 1", cfg_err);
        end
        for (int i = 2; i < 2048; i++) req(1'b0, $urandom, 1'($urandom));
        req(1'b1, 8, 1'b1);
        req(1'b0, 0, 1'b0);
        req(1'b1, 3, 1'b0);
        req(1'b0, 0, 1'b0);
        req(1'b1, 64, 1'b0);
        req(1'b0, 0, 1'b0);
        idle(6);
        n_chk++;
        if (got_q.size() != exp_q.size() || cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_count: got %0d outputs err=%b, required %0d err=1", got_q.size(), cfg_err, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i].cos_v !== exp_q[i].cos_v || got_q[i].sin_v !== exp_q[i].sin_v || got_q[i].sop !== exp_q[i].sop
                || got_q[i].eop !== exp_q[i].eop || got_q[i].t - exp_q[i].t !== 3) begin
                n_fail++;
                $display("FAIL cfg_item %0d: got cos=%0d sin=%0d sop=%0d eop=%0d, required cos=%0d sin=%0d sop=%0d eop=%0d",
                         i, got_q[i].cos_v, got_q[i].sin_v, got_q[i].sop, got_q[i].eop,
                         exp_q[i].cos_v, exp_q[i].sin_v, exp_q[i].sop, exp_q[i].eop);
            end
        end
    endtask

    task automatic test_reset_midframe;
        exp_q.delete(); got_q.delete();
        req(1'b1, 64, 1'b1);
        for (int i = 1; i < 20; i++) req(1'b0, $urandom, 1'($urandom));
        @(posedge clk); #1;
        rst_n_sync = 1'b0;
        #1;
        n_chk++;
        if ({source_valid, source_sop, source_eop, cfg_err} !== 4'b0 || source_cos !== '0 || source_sin !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b sop=%b eop=%b err=%b cos=%0d sin=%0d, required all 0",
                     source_valid, source_sop, source_eop, cfg_err, source_cos, source_sin);
        end
        idle(3);
        exp_q.delete(); got_q.delete();
        m_k = 0; m_n = NMAX; m_inv = 1'b0;
        @(negedge clk) rst_n_sync = 1'b1;
        for (int i = 0; i < 5; i++) req(1'b0, $urandom, 1'($urandom));
        idle(6);
        n_chk++;
        if (got_q.size() != 5 || got_q[0].sop !== 1'b1 || got_q[0].cos_v !== 46341 || got_q[0].sin_v !== 0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_first: got n=%0d sop=%0d cos=%0d sin=%0d err=%b, required 5 1 46341 0 0",
                     got_q.size(), got_q[0].sop, got_q[0].cos_v, got_q[0].sin_v, cfg_err);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_chk++;
            if (got_q[i].cos_v !== exp_q[i].cos_v || got_q[i].sin_v !== exp_q[i].sin_v || got_q[i].sop !== exp_q[i].sop
                || got_q[i].t - exp_q[i].t !== 3) begin
                n_fail++;
                $display("FAIL midreset_item %0d: got cos=%0d sin=%0d sop=%0d, required cos=%0d sin=%0d sop=%0d",
                         i, got_q[i].cos_v, got_q[i].sin_v, got_q[i].sop, exp_q[i].cos_v, exp_q[i].sin_v, exp_q[i].sop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_2048();
        test_inverse_16();
        test_gaps_64();
        test_resync();
        test_random();
        test_cfg_err();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
